mcu_clk_gate_ctrl: RTL and testbench



---
 rtl/mcu_clk_gate_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mcu_clk_gate_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mcu_clk_gate_ctrl.sv
// mcu_clk_gate_ctrl: sleep/wake controller producing the enable for the MCU
// core clock gate. It runs on the free-running ungated clock. The core clock
// is gated only after core_sleep_i has been held for an idle dwell, and is
// kept on for a minimum window after a wake.
//
// Ports:
//   clk_i          free-running (ungated) MCU clock
//   rst_ni         synchronous active-low reset
//   core_sleep_i   core reports sleep (WFI retired, pipeline idle)
//   irq_pending_i  any enabled interrupt pending (level)
//   debug_req_i    debug request (level)
//   force_on_i     software/test override, keeps the clock running
//   stats_clr_i    clears the gated-cycle counter (stats build only)
//   clk_en_o       registered enable to the clock gate
//   gated_o        high while in GATED
//   gate_cnt_o     number of GATED entries, saturating
//   gated_cycles_o cycles spent with clk_en_o=0, saturating (stats build only)
//
// Optional feature: define MCU_CG_STATS_EN to build the gated-cycle counter.
// Without it, gated_cycles_o is tied to zero and stats_clr_i is ignored.
module mcu_clk_gate_ctrl #(
  parameter int unsigned IDLE_CYCLES = 8,
  parameter int unsigned WAKE_HOLD   = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             core_sleep_i,
  input  logic             irq_pending_i,
  input  logic             debug_req_i,
  input  logic             force_on_i,
  input  logic             stats_clr_i,
  output logic             clk_en_o,
  output logic             gated_o,
  output logic [CNT_W-1:0] gate_cnt_o,
  output logic [31:0]      gated_cycles_o
);

  localparam int unsigned DWELL_W = 8;
  localparam logic [DWELL_W-1:0] IDLE_LIM = DWELL_W'(IDLE_CYCLES);
  localparam logic [DWELL_W-1:0] HOLD_LIM = DWELL_W'(WAKE_HOLD);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_GATED = 2'd2,
    ST_WAKE  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 clk_en_q, clk_en_d;
  logic                 gated_q, gated_d;
  logic [CNT_W-1:0]     gate_cnt_q, gate_cnt_d;
  logic                 wake_evt;

  assign wake_evt = irq_pending_i | debug_req_i | force_on_i;

  // State, dwell/hold counter and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      clk_en_q   <= 1'b1;
      gated_q    <= 1'b0;
      gate_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clk_en_q   <= clk_en_d;
      gated_q    <= gated_d;
      gate_cnt_q <= gate_cnt_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they
  // reflect the new state from the edge that takes the transition.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gate_cnt_d = gate_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (core_sleep_i && !wake_evt) begin
          state_d = ST_DRAIN;
          cnt_d   = DWELL_W'(1);
        end
      end
      ST_DRAIN: begin
        // A wake on the final dwell cycle beats the gating decision.
        if (!core_sleep_i || wake_evt) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q == IDLE_LIM) begin
          state_d = ST_GATED;
          cnt_d   = '0;
          if (gate_cnt_q != {CNT_W{1'b1}}) begin
            gate_cnt_d = gate_cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      ST_GATED: begin
        if (wake_evt || !core_sleep_i) begin
          state_d = ST_WAKE;
          cnt_d   = '0;
        end
      end
      ST_WAKE: begin
        // Hold window: sleep and further wake events are ignored here.
        if (cnt_q == HOLD_LIM) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
    clk_en_d = (state_d != ST_GATED);
    gated_d  = (state_d == ST_GATED);
  end

  assign clk_en_o   = clk_en_q;
  assign gated_o    = gated_q;
  assign gate_cnt_o = gate_cnt_q;

`ifdef MCU_CG_STATS_EN
  logic [31:0] gated_cycles_q, gated_cycles_d;

  // Count cycles with the enable low; clear has priority over increment.
  always_comb begin
    gated_cycles_d = gated_cycles_q;
    if (stats_clr_i) begin
      gated_cycles_d = '0;
    end else if (!clk_en_q && (gated_cycles_q != 32'hFFFF_FFFF)) begin
      gated_cycles_d = gated_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      gated_cycles_q <= '0;
    end else begin
      gated_cycles_q <= gated_cycles_d;
    end
  end

  assign gated_cycles_o = gated_cycles_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr_i;
  assign gated_cycles_o   = 32'h0;
`endif

endmodule

// File: tb/tb_mcu_clk_gate_ctrl.sv
// Testbench for mcu_clk_gate_ctrl: directed scenarios followed by random
// stimulus. The driver updates a behavioural model and queues the expected
// outputs; a monitor pops and compares one entry after every clock edge.
module tb_mcu_clk_gate_ctrl;

  localparam int unsigned IDLE_CYCLES = 8;
  localparam int unsigned WAKE_HOLD   = 4;
  localparam int unsigned CNT_W       = 3;
  localparam int unsigned CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             core_sleep_i = 1'b0;
  logic             irq_pending_i = 1'b0;
  logic             debug_req_i = 1'b0;
  logic             force_on_i = 1'b0;
  logic             stats_clr_i = 1'b0;
  logic             clk_en_o;
  logic             gated_o;
  logic [CNT_W-1:0] gate_cnt_o;
  logic [31:0]      gated_cycles_o;

  mcu_clk_gate_ctrl #(
    .IDLE_CYCLES(IDLE_CYCLES),
    .WAKE_HOLD  (WAKE_HOLD),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .core_sleep_i  (core_sleep_i),
    .irq_pending_i (irq_pending_i),
    .debug_req_i   (debug_req_i),
    .force_on_i    (force_on_i),
    .stats_clr_i   (stats_clr_i),
    .clk_en_o      (clk_en_o),
    .gated_o       (gated_o),
    .gate_cnt_o    (gate_cnt_o),
    .gated_cycles_o(gated_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic             en;
    logic             gated;
    logic [CNT_W-1:0] gcnt;
    logic [31:0]      gcyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model: clock is gated or not; a run of qualifying sleep samples; the
  // number of hold cycles still owed after a wake.
  bit          m_gated     = 1'b0;
  int          m_streak    = 0;
  int          m_wake_left = 0;
  int          m_gate_cnt  = 0;
  logic [31:0] m_gcyc      = '0;

  // Apply one cycle of inputs at the falling edge and queue what the DUT
  // must show after the next rising edge.
  task automatic drive(input bit rst, input bit slp, input bit irq,
                       input bit dbg, input bit frc, input bit clr);
    bit   wake;
    bit   was_gated;
    exp_t e;
    @(negedge clk_i);
    rst_ni        = rst;
    core_sleep_i  = slp;
    irq_pending_i = irq;
    debug_req_i   = dbg;
    force_on_i    = frc;
    stats_clr_i   = clr;
    wake      = irq | dbg | frc;
    was_gated = m_gated;
    if (!rst) begin
      m_gated = 1'b0; m_streak = 0; m_wake_left = 0; m_gate_cnt = 0; m_gcyc = '0;
    end else begin
      if (m_gated) begin
        if (wake || !slp) begin
          m_gated     = 1'b0;
          m_wake_left = WAKE_HOLD + 1;
        end
      end else if (m_wake_left > 0) begin
        m_wake_left--;
      end else if (slp && !wake) begin
        m_streak++;
        if (m_streak == IDLE_CYCLES + 1) begin
          m_gated  = 1'b1;
          m_streak = 0;
          if (m_gate_cnt < CNT_MAX) m_gate_cnt++;
        end
      end else begin
        m_streak = 0;
      end
      if (clr) m_gcyc = '0;
      else if (was_gated && m_gcyc != 32'hFFFF_FFFF) m_gcyc = m_gcyc + 32'd1;
    end
    e.en    = !m_gated;
    e.gated = m_gated;
    e.gcnt  = CNT_W'(m_gate_cnt);
`ifdef MCU_CG_STATS_EN
    e.gcyc  = m_gcyc;
`else
    e.gcyc  = 32'h0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic rep(input int n, input bit rst, input bit slp, input bit irq,
                     input bit dbg, input bit frc, input bit clr);
    for (int i = 0; i < n; i++) drive(rst, slp, irq, dbg, frc, clr);
  endtask

  // Monitor: one output set per rising edge, sampled 1 time unit later.
  always @(posedge clk_i) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (clk_en_o !== e.en) begin
        n_fail++;
        $display("FAIL clk_en t=%0t got=%0b exp=%0b", $time, clk_en_o, e.en);
      end
      n_checks++;
      if (gated_o !== e.gated) begin
        n_fail++;
        $display("FAIL gated t=%0t got=%0b exp=%0b", $time, gated_o, e.gated);
      end
      n_checks++;
      if (gate_cnt_o !== e.gcnt) begin
        n_fail++;
        $display("FAIL gate_cnt t=%0t got=%0d exp=%0d", $time, gate_cnt_o, e.gcnt);
      end
      n_checks++;
      if (gated_cycles_o !== e.gcyc) begin
        n_fail++;
        $display("FAIL gated_cycles t=%0t got=%0d exp=%0d", $time, gated_cycles_o, e.gcyc);
      end
    end
  end

  initial begin
    // Reset held with sleep asserted, then gate after the idle dwell.
    rep(3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    rep(14, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Wake and settle in RUN.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    rep(8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Dwell abort, then a full dwell.
    rep(5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    rep(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rep(12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // One-cycle irq pulse while gated, sleep held through the hold window.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    rep(20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Reset mid-GATED.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    rep(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Race: debug request on the final dwell sample.
    rep(IDLE_CYCLES, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    rep(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Override keeps the clock on.
    rep(100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    rep(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Stats: 20 gated cycles, clear while gated, resume counting.
    rep(IDLE_CYCLES + 1 + 20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    rep(5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Repeated gate/wake cycles to saturate the gate counter.
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rep(WAKE_HOLD + 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rep(IDLE_CYCLES + 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(99) != 0,
            $urandom_range(99) < 85,
            $urandom_range(99) < 5,
            $urandom_range(99) < 3,
            $urandom_range(99) < 3,
            $urandom_range(99) < 4);
    end
    rep(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
